// File: rtl/mcx_pkg.sv
// Shared definitions for the MCX program-memory line interface and its loader.
package mcx_pkg;

  localparam int unsigned LINE_W    = 46;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned SHIFT_W   = 48;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LINES_W   = 5;
  localparam int unsigned TIMEOUT   = 1023;
  localparam int unsigned TIMEOUT_W = 10;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] END_BYTE  = 8'hFF;

  // Field bit positions within a program line
  localparam int unsigned PC_MSB   = 45;
  localparam int unsigned PC_LSB   = 42;
  localparam int unsigned COND_MSB = 41;
  localparam int unsigned COND_LSB = 40;
  localparam int unsigned INST_MSB = 39;
  localparam int unsigned INST_LSB = 36;
  localparam int unsigned ARG0_MSB = 35;
  localparam int unsigned ARG0_LSB = 24;
  localparam int unsigned ARG1_MSB = 23;
  localparam int unsigned ARG1_LSB = 12;
  localparam int unsigned ARG2_MSB = 11;
  localparam int unsigned ARG2_LSB = 0;

  typedef struct packed {
    logic [3:0]  pc;
    logic [1:0]  cond;
    logic [3:0]  inst;
    logic [11:0] arg0;
    logic [11:0] arg1;
    logic [11:0] arg2;
  } mcx_line_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CHK,
    WRITE,
    END
  } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for in-frame byte gaps; expired_c fires on the cycle the
// count would reach TIMEOUT.
module loader_timeout
  import mcx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_val,
  output logic                 expired_c
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != TIMEOUT_W'(TIMEOUT))) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired_c = inc && !clr && (count == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-serial program loader: parses framed lines, verifies the XOR checksum and
// writes prog_mem, holding the MCX core in reset until an end-of-load frame.
module prog_loader
  import mcx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [LINE_W-1:0]  wr_data,
  output logic               core_hold,
  output logic               load_done,
  output logic               frame_err,
  output logic [LINES_W-1:0] lines_written
);

  loader_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic                ready_d, wr_en_d, hold_d, done_d, err_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [LINE_W-1:0]   wr_data_d;
  logic [LINES_W-1:0]  lines_d;
  logic                accept_c, in_frame_c, expired_c;
  mcx_line_t           line_c;

  assign accept_c   = in_valid && in_ready;
  assign in_frame_c = (state_q == ADDR) || (state_q == DATA) ||
                      (state_q == CHK)  || (state_q == END);
  assign line_c     = mcx_line_t'(shift_q[LINE_W-1:0]);

  loader_timeout u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr       (!in_frame_c || accept_c),
    .inc       (in_frame_c && !accept_c),
    .load      (1'b0),
    .load_val  ('0),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      shift_q       <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      in_ready      <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      core_hold     <= 1'b1;
      load_done     <= 1'b0;
      frame_err     <= 1'b0;
      lines_written <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      in_ready      <= ready_d;
      wr_en         <= wr_en_d;
      wr_addr       <= wr_addr_d;
      wr_data       <= wr_data_d;
      core_hold     <= hold_d;
      load_done     <= done_d;
      frame_err     <= err_d;
      lines_written <= lines_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    hold_d    = core_hold;
    done_d    = 1'b0;
    err_d     = frame_err;
    lines_d   = lines_written;

    case (state_q)
      IDLE: begin
        if (accept_c && (in_data == SYNC_BYTE)) begin
          err_d   = 1'b0;
          csum_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (accept_c) begin
          if (in_data[7:ADDR_W] == '0) begin
            addr_d  = in_data[ADDR_W-1:0];
            csum_d  = csum_q ^ in_data;
            idx_d   = '0;
            state_d = DATA;
          end else if (in_data == END_BYTE) begin
            state_d = END;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], in_data};
          csum_d  = csum_q ^ in_data;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(5)) state_d = CHK;
        end
      end
      CHK: begin
        if (accept_c) begin
          if (in_data == csum_q) begin
            // Re-hold the core before its memory changes
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = line_c;
            hold_d    = 1'b1;
            if (lines_written != '1) lines_d = lines_written + LINES_W'(1);
            state_d   = WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WRITE: state_d = IDLE;
      END: begin
        if (accept_c) begin
          if (in_data == END_BYTE) begin
            hold_d = 1'b0;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (expired_c) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end

    ready_d = (state_d != WRITE);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame-level model predicts writes, errors and
// end-of-load; a negedge monitor checks every write strobe and the line counter.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [45:0] wr_data;
  logic        core_hold;
  logic        load_done;
  logic        frame_err;
  logic [4:0]  lines_written;

  prog_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .core_hold     (core_hold),
    .load_done     (load_done),
    .frame_err     (frame_err),
    .lines_written (lines_written)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  frame_q[$];
  logic [3:0]  wq_addr[$];
  logic [45:0] wq_data[$];
  int          done_exp  = 0;
  int          exp_lines = 0;
  logic        exp_err   = 1'b0;
  logic        exp_hold  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i]);
  endtask

  // Frame-level prediction of what a complete frame in frame_q should do
  task automatic model_frame();
    logic [7:0]  cs;
    logic [47:0] d;
    logic [7:0]  a;
    if (frame_q.size() < 2 || frame_q[0] != 8'hA5) return;
    exp_err = 1'b0;
    a = frame_q[1];
    if (a == 8'hFF) begin
      if (frame_q.size() == 3 && frame_q[2] == 8'hFF) begin
        exp_hold = 1'b0;
        done_exp++;
      end else begin
        exp_err = 1'b1;
      end
    end else if (a < 8'd16) begin
      if (frame_q.size() != 9) return;
      cs = a;
      d  = '0;
      for (int i = 2; i < 8; i++) begin
        cs ^= frame_q[i];
        d = {d[39:0], frame_q[i]};
      end
      if (frame_q[8] == cs) begin
        wq_addr.push_back(a[3:0]);
        wq_data.push_back(d[45:0]);
        exp_hold = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic build_line(input logic [3:0] a, input logic [47:0] d, input bit good);
    logic [7:0] cs;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back({4'h0, a});
    cs = {4'h0, a};
    for (int i = 5; i >= 0; i--) begin
      b = d[i*8 +: 8];
      frame_q.push_back(b);
      cs ^= b;
    end
    frame_q.push_back(good ? cs : ~cs);
  endtask

  task automatic run_model_frame();
    model_frame();
    send_frame();
  endtask

  task automatic settle_check(input string name);
    repeat (3) @(negedge clk);
    chk({name, "_err"}, 64'(frame_err), 64'(exp_err));
    chk({name, "_hold"}, 64'(core_hold), 64'(exp_hold));
    chk({name, "_pending_writes"}, 64'(wq_addr.size()), 64'd0);
    chk({name, "_pending_done"}, 64'(done_exp), 64'd0);
  endtask

  // Per-cycle monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_lines = 0;
    end else begin
      if (wr_en) begin
        if (wq_addr.size() == 0) begin
          chk("unexpected_wr_en", 64'(wr_en), 64'd0);
        end else begin
          chk("wr_addr", 64'(wr_addr), 64'(wq_addr.pop_front()));
          chk("wr_data", 64'(wr_data), 64'(wq_data.pop_front()));
          if (exp_lines < 31) exp_lines++;
        end
        chk("ready_in_write", 64'(in_ready), 64'd0);
        chk("hold_in_write", 64'(core_hold), 64'd1);
      end
      if (load_done) begin
        chk("load_done_expected", 64'(done_exp > 0), 64'd1);
        if (done_exp > 0) done_exp--;
        chk("hold_at_done", 64'(core_hold), 64'd0);
      end
      chk("lines_written", 64'(lines_written), 64'(exp_lines));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_core_hold", 64'(core_hold), 64'd1);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_lines", 64'(lines_written), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Hand-computed line write
    frame_q = '{8'hA5, 8'h03, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h91};
    wq_addr.push_back(4'h3);
    wq_data.push_back(46'h00123456789A);
    send_frame();
    settle_check("line1");
    chk("line1_lines", 64'(lines_written), 64'd1);
    chk("hold_wr_addr", 64'(wr_addr), 64'h3);
    chk("hold_wr_data", 64'(wr_data), 64'h00123456789A);

    // Bad checksum, then a bare SYNC clears the error
    frame_q = '{8'hA5, 8'h03, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h90};
    run_model_frame();
    settle_check("badcs");
    chk("badcs_err_lit", 64'(frame_err), 64'd1);
    send_byte(8'hA5);
    chk("sync_clears_err", 64'(frame_err), 64'd0);
    frame_q = '{8'hA5, 8'h03, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h91};
    model_frame();
    for (int i = 1; i < 9; i++) send_byte(frame_q[i]);
    settle_check("rewrite");
    chk("rewrite_lines", 64'(lines_written), 64'd2);

    // Bad address followed by stray bytes
    frame_q = '{8'hA5, 8'h20};
    run_model_frame();
    frame_q = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h91};
    send_frame();
    settle_check("badaddr");
    chk("badaddr_err_lit", 64'(frame_err), 64'd1);

    // End of load
    frame_q = '{8'hA5, 8'hFF, 8'hFF};
    run_model_frame();
    settle_check("end");
    chk("end_hold_lit", 64'(core_hold), 64'd0);

    // Line after load re-holds the core; SYNC value as data payload
    frame_q = '{8'hA5, 8'h07, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h06};
    run_model_frame();
    settle_check("reload");
    chk("reload_hold_lit", 64'(core_hold), 64'd1);

    // Malformed end frame leaves hold alone
    frame_q = '{8'hA5, 8'hFF, 8'h12};
    run_model_frame();
    settle_check("badend");

    // Idle timeout inside a frame
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h12);
    repeat (1022) @(posedge clk);
    #1 chk("timeout_minus1_err", 64'(frame_err), 64'd0);
    @(posedge clk);
    #1 chk("timeout_err", 64'(frame_err), 64'd1);
    exp_err = 1'b1;
    build_line(4'hC, 48'hC0FE_DCBA_9876, 1'b1);
    run_model_frame();
    settle_check("after_timeout");

    // Reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
    chk("mid_rst_hold", 64'(core_hold), 64'd1);
    chk("mid_rst_done", 64'(load_done), 64'd0);
    chk("mid_rst_err", 64'(frame_err), 64'd0);
    chk("mid_rst_lines", 64'(lines_written), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_err  = 1'b0;
    exp_hold = 1'b1;

    for (int a = 0; a < 16; a++) begin
      build_line(4'(a), {2'(a), 46'(a * 46'h0123_4567_89B) ^ 46'h15A5}, 1'b1);
      run_model_frame();
    end
    settle_check("sweep");
    chk("sweep_lines_lit", 64'(lines_written), 64'd16);

    for (int a = 0; a < 16; a++) begin
      build_line(4'(15 - a), {2'b11, 46'(a) << 20}, 1'b1);
      run_model_frame();
    end
    settle_check("saturate");
    chk("saturate_lines_lit", 64'(lines_written), 64'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
